// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : Synchronises and debounces add/sub buttons and emits one-cycle
//            set pulses with hold-then-auto-repeat behaviour.
// Revision : 1.0  initial release
// ============================================================================
module button_conditioner #(
    parameter int DEBOUNCE  = 4,
    parameter int HOLD      = 16,
    parameter int REPEAT    = 4,
    parameter int CNT_WIDTH = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic power,
    input  logic enable,
    input  logic add_btn,
    input  logic sub_btn,
    output logic add_time,
    output logic sub_time,
    output logic busy
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_DEB_PRESS   = 3'd1,
        S_HOLD        = 3'd2,
        S_REPEAT      = 3'd3,
        S_DEB_RELEASE = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_deb_last  = CNT_WIDTH'(DEBOUNCE - 1);
    localparam logic [CNT_WIDTH-1:0] c_hold_last = CNT_WIDTH'(HOLD - 1);
    localparam logic [CNT_WIDTH-1:0] c_rep_last  = CNT_WIDTH'(REPEAT - 1);

    logic [1:0]           add_sync_q, sub_sync_q;
    state_t               state_q, state_d;
    logic                 dir_q, dir_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 add_time_q, add_time_d;
    logic                 sub_time_q, sub_time_d;
    logic                 busy_q, busy_d;

    logic                 w_add, w_sub, w_sel, w_set_ok, w_pulse;
    logic [CNT_WIDTH-1:0] w_cnt_inc;

    assign w_add     = add_sync_q[1];
    assign w_sub     = sub_sync_q[1];
    assign w_sel     = dir_q ? w_sub : w_add;
    assign w_set_ok  = power & ~enable;
    // Saturating increment: the counter parks at all-ones instead of wrapping.
    assign w_cnt_inc = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = w_cnt_inc;
        w_pulse = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (w_set_ok && (w_add ^ w_sub)) begin
                    dir_d   = w_sub;
                    state_d = S_DEB_PRESS;
                end
            end
            S_DEB_PRESS: begin
                if (!w_sel) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == c_deb_last) begin
                    w_pulse = 1'b1;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!w_sel) begin
                    cnt_d   = '0;
                    state_d = S_DEB_RELEASE;
                end else if (cnt_q == c_hold_last) begin
                    w_pulse = 1'b1;
                    cnt_d   = '0;
                    state_d = S_REPEAT;
                end
            end
            S_REPEAT: begin
                if (!w_sel) begin
                    cnt_d   = '0;
                    state_d = S_DEB_RELEASE;
                end else if (cnt_q == c_rep_last) begin
                    w_pulse = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_DEB_RELEASE: begin
                if (w_add || w_sub) begin
                    cnt_d = '0;
                end else if (cnt_q == c_deb_last) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Losing set permission aborts any active press; release debounce still applies.
        if (!w_set_ok && (state_q != S_IDLE) && (state_q != S_DEB_RELEASE)) begin
            w_pulse = 1'b0;
            cnt_d   = '0;
            state_d = S_DEB_RELEASE;
        end

        add_time_d = w_pulse & ~dir_q;
        sub_time_d = w_pulse & dir_q;
        busy_d     = power & (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            add_sync_q <= 2'b00;
            sub_sync_q <= 2'b00;
            state_q    <= S_IDLE;
            dir_q      <= 1'b0;
            cnt_q      <= '0;
            add_time_q <= 1'b0;
            sub_time_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            add_sync_q <= {add_sync_q[0], add_btn};
            sub_sync_q <= {sub_sync_q[0], sub_btn};
            state_q    <= state_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            add_time_q <= add_time_d;
            sub_time_q <= sub_time_d;
            busy_q     <= busy_d;
        end
    end

    assign add_time = add_time_q;
    assign sub_time = sub_time_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire
